// File: rtl/ky11_blkmove.sv
// ky11_blkmove: block-transfer engine driving KY's DMA address/data registers.
// One ARM command moves a run of Unibus words or bytes through a 16-word FIFO.
module ky11_blkmove #(
  parameter int FIFOLOG = 4,
  parameter int POLLMAX = 2047
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  input  logic        ky_armbusy,
  output logic        ky_write,
  output logic [2:0]  ky_waddr,
  output logic [31:0] ky_wdata,
  output logic [2:0]  ky_raddr,
  input  logic [31:0] ky_rdata
);
  localparam int DEPTH = 1 << FIFOLOG;
  localparam int WDW = $clog2(POLLMAX + 2);
  localparam logic [WDW-1:0] WDMAX = WDW'(POLLMAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_POLL  = 3'd3,
    S_FETCH = 3'd4,
    S_NEXT  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  state_t state;
  logic busy, fail, abort_pend, polled;
  logic [1:0] ctrl;
  logic [17:0] curaddr;
  logic [11:0] remaining;
  logic [WDW-1:0] wd;

  logic [15:0] fifo [DEPTH];
  logic [FIFOLOG-1:0] wptr, rptr;
  logic [FIFOLOG:0] level;
  logic [15:0] head, pdata;
  logic empty, full;

  logic wr1, start_wr, abort_wr, arm_push, arm_pop;
  logic dati, done, abort_any, poll_done;
  logic load_go, start_go, abort_go, flush;
  logic push, do_push, do_pop;
  logic unused_ok;

  assign head = fifo[rptr];
  assign empty = (level == '0);
  assign full = level[FIFOLOG];

  assign wr1 = armwrite && (armwaddr == 3'd1);
  assign start_wr = wr1 && armwdata[31];
  assign abort_wr = wr1 && armwdata[30];
  assign arm_push = armwrite && (armwaddr == 3'd3);
  assign arm_pop = armwrite && (armwaddr == 3'd4);

  assign dati = (ctrl == 2'd0);
  assign done = (ky_rdata[31:29] == 3'd0);
  assign abort_any = abort_wr || abort_pend;
  assign poll_done = (state == S_POLL) && polled && done;

  // A bus write is only issued in a cycle the ARM leaves KY alone
  assign load_go = (state == S_LOAD) && !empty
                   && !ky_armbusy && !abort_wr;
  assign start_go = (state == S_START) && !(dati && full)
                    && !ky_armbusy && !abort_wr;
  assign abort_go = abort_any && ((state == S_LOAD)
                    || (state == S_START) || (state == S_NEXT)
                    || (poll_done && !ky_rdata[28]));
  assign flush = abort_go || ((state == S_IDLE) && start_wr
                 && (remaining != '0) && (armwdata[27:26] == 2'd0));

  assign push = (state == S_FETCH) || arm_push;
  assign pdata = (state == S_FETCH) ? ky_rdata[15:0] : armwdata[15:0];
  assign do_pop = (load_go || arm_pop) && !empty;
  assign do_push = push && (!full || do_pop);

  assign unused_ok = ^{init_in_h, ky_rdata[27:16],
                       armwdata[29:28], armwdata[25:18]};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && !do_pop) level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (do_push && !flush) fifo[wptr] <= pdata;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      busy <= 1'b0;
      fail <= 1'b0;
      abort_pend <= 1'b0;
      polled <= 1'b0;
      ctrl <= 2'd0;
      curaddr <= '0;
      remaining <= '0;
      wd <= '0;
    end else begin
      if (armwrite && (armwaddr == 3'd2) && (state == S_IDLE))
        remaining <= armwdata[11:0];
      // A bus cycle in flight is never abandoned; abort waits for done
      if (abort_wr && ((state == S_POLL) || (state == S_FETCH)))
        abort_pend <= 1'b1;
      if (abort_go) begin
        state <= S_IDLE;
        busy <= 1'b0;
        fail <= 1'b1;
        abort_pend <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_wr) begin
              ctrl <= armwdata[27:26];
              curaddr <= armwdata[17:0];
              if (remaining != '0) begin
                busy <= 1'b1;
                fail <= 1'b0;
                state <= (armwdata[27:26] == 2'd0) ? S_START : S_LOAD;
              end
            end
          end
          S_LOAD: if (load_go) state <= S_START;
          S_START: begin
            if (start_go) begin
              state <= S_POLL;
              polled <= 1'b0;
              wd <= '0;
            end
          end
          S_POLL: begin
            polled <= 1'b1;
            if (polled) begin
              if (done && ky_rdata[28]) begin
                state <= S_FAIL;
                busy <= 1'b0;
                fail <= 1'b1;
                abort_pend <= 1'b0;
              end else if (done) begin
                state <= dati ? S_FETCH : S_NEXT;
              end else if (wd == WDMAX) begin
                state <= S_FAIL;
                busy <= 1'b0;
                fail <= 1'b1;
                abort_pend <= 1'b0;
              end else begin
                wd <= wd + 1'b1;
              end
            end
          end
          S_FETCH: state <= S_NEXT;
          S_NEXT: begin
            curaddr <= curaddr + ((ctrl == 2'd3) ? 18'd1 : 18'd2);
            remaining <= remaining - 1'b1;
            if (remaining == 12'd1) begin
              state <= S_IDLE;
              busy <= 1'b0;
            end else begin
              state <= dati ? S_START : S_LOAD;
            end
          end
          S_FAIL: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ky_write = load_go || start_go;
    ky_waddr = 3'd0;
    ky_wdata = 32'd0;
    ky_raddr = (state == S_FETCH) ? 3'd4 : 3'd3;
    if (load_go) begin
      ky_waddr = 3'd4;
      ky_wdata = {16'd0, head};
    end else if (start_go) begin
      ky_waddr = 3'd3;
      ky_wdata = {2'b00, 1'b1, 1'b0, ctrl, 8'd0, curaddr};
    end
  end

  always_comb begin
    armrdata = 32'd0;
    case (armraddr)
      3'd0: armrdata = 32'h424D2001;
      3'd1: armrdata = {busy, fail, state, ctrl, 7'd0, curaddr};
      3'd2: armrdata = {4'd0, remaining, 11'd0, level};
      3'd3: armrdata = {15'd0, !empty, head};
      default: armrdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_ky11_blkmove.sv
// tb_ky11_blkmove: scoreboard bench with a behavioural KY model.
// Expected KY writes are queued by stimulus and popped by a monitor.
module tb_ky11_blkmove;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        armwrite = 1'b0;
  logic [2:0]  armraddr = 3'd0;
  logic [2:0]  armwaddr = 3'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic        init_in_h = 1'b0;
  logic        ky_armbusy;
  logic        ky_write;
  logic [2:0]  ky_waddr;
  logic [31:0] ky_wdata;
  logic [2:0]  ky_raddr;
  logic [31:0] ky_rdata;

  logic force_busy = 1'b0;
  logic noise_en = 1'b0;
  logic noise_bit = 1'b0;
  assign ky_armbusy = force_busy | (noise_en & noise_bit);

  ky11_blkmove dut (
    .CLOCK(clk), .RESET(rst),
    .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata),
    .armrdata(armrdata), .init_in_h(init_in_h),
    .ky_armbusy(ky_armbusy), .ky_write(ky_write),
    .ky_waddr(ky_waddr), .ky_wdata(ky_wdata),
    .ky_raddr(ky_raddr), .ky_rdata(ky_rdata)
  );

  int nchk = 0;
  int nfail = 0;

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
  } kyw_t;
  kyw_t exp_q[$];
  kyw_t mon_e;
  logic [15:0] dq[$];
  logic [15:0] dati_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // KY model: a DMA start runs for lat cycles, then completes or fails
  logic [2:0]  kst;
  logic        kfail;
  logic [1:0]  kctrl;
  logic [17:0] kaddr;
  logic [15:0] kdbuf;
  int kcnt;
  int lat = 2;
  int fail_at = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kst <= 3'd0;
      kfail <= 1'b0;
      kctrl <= 2'd0;
      kaddr <= 18'd0;
      kdbuf <= 16'd0;
      kcnt <= 0;
    end else if (ky_write && ky_waddr == 3'd3 && ky_wdata[29]) begin
      kst <= 3'd1;
      kfail <= 1'b0;
      kctrl <= ky_wdata[27:26];
      kaddr <= ky_wdata[17:0];
      kcnt <= lat;
    end else begin
      if (ky_write && ky_waddr == 3'd4) kdbuf <= ky_wdata[15:0];
      if (kst != 3'd0) begin
        if (kcnt <= 1) begin
          kst <= 3'd0;
          if (int'(kaddr) == fail_at) kfail <= 1'b1;
          else if (kctrl == 2'd0 && dati_q.size() > 0)
            kdbuf <= dati_q.pop_front();
        end else begin
          kcnt <= kcnt - 1;
        end
      end
    end
  end

  assign ky_rdata = (ky_raddr == 3'd3) ?
                    {kst, kfail, kctrl, 8'd0, kaddr} :
                    (ky_raddr == 3'd4) ? {16'd0, kdbuf} : 32'd0;

  initial forever begin
    @(posedge clk);
    #1;
    noise_bit = ($urandom_range(0, 2) == 0);
  end

  initial forever begin
    @(negedge clk);
    if (ky_write === 1'b1) begin
      chk("kyw_armbusy", {31'd0, ky_armbusy}, 32'd0);
      if (exp_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL kyw_unexpected: got waddr %0d wdata %h, required no write",
                 ky_waddr, ky_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("kyw_addr", {29'd0, ky_waddr}, {29'd0, mon_e.a});
        chk("kyw_data", ky_wdata, mon_e.d);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    @(posedge clk);
    #1;
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [31:0] r;
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      arm_rd(3'd1, r);
      if (r[31] == 1'b0 && r[29:27] == 3'd0) begin
        ok = 1;
        break;
      end
      cycles(1);
    end
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got busy after %0d cycles, required idle", name, budget);
    end
  endtask

  function automatic logic [31:0] r3w(logic [1:0] c, logic [17:0] a);
    return {2'b00, 1'b1, 1'b0, c, 8'd0, a};
  endfunction

  // Reference: word i touches a0 + i*step (mod 2^18), DATO loads data first
  task automatic run_xfer(input logic [1:0] c, input logic [17:0] a0,
                          input int n, output logic [17:0] aend);
    logic [17:0] a = a0;
    for (int i = 0; i < n; i++) begin
      if (c != 2'd0) exp_q.push_back({3'd4, {16'd0, dq[i]}});
      exp_q.push_back({3'd3, r3w(c, a)});
      a = a + ((c == 2'd3) ? 18'd1 : 18'd2);
    end
    aend = a;
    for (int i = 0; i < n; i++) begin
      if (c != 2'd0) arm_wr(3'd3, {16'd0, dq[i]});
      else dati_q.push_back(dq[i]);
    end
    arm_wr(3'd2, 32'(n));
    arm_wr(3'd1, {1'b1, 1'b0, 2'b00, c, 8'd0, a0});
  endtask

  task automatic pop_check(input string name, input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      arm_rd(3'd3, r);
      chk(name, r, {15'd0, 1'b1, dq[i]});
      arm_wr(3'd4, 32'd0);
    end
  endtask

  logic [31:0] r;
  logic [17:0] aend;
  logic [15:0] refq[$];

  initial begin
    #12;
    chk("rst_kywrite", {31'd0, ky_write}, 32'd0);
    chk("rst_kywaddr", {29'd0, ky_waddr}, 32'd0);
    chk("rst_kywdata", ky_wdata, 32'd0);
    chk("rst_kyraddr", {29'd0, ky_raddr}, 32'd3);
    arm_rd(3'd0, r);
    chk("id", r, 32'h424D2001);
    arm_rd(3'd1, r);
    chk("rst_reg1", r, 32'd0);
    arm_rd(3'd2, r);
    chk("rst_reg2", r, 32'd0);
    arm_rd(3'd3, r);
    chk("rst_valid", {31'd0, r[16]}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(2);

    // FIFO: 17 pushes keep 16, extra pop is ignored
    for (int i = 0; i < 17; i++) begin
      arm_wr(3'd3, 32'hABC0_0000 | 32'($urandom_range(0, 65535)));
      if (refq.size() < 16) refq.push_back(armwdata[15:0]);
    end
    arm_rd(3'd2, r);
    chk("fifo_full_level", r, 32'd16);
    while (refq.size() > 0) begin
      arm_rd(3'd3, r);
      chk("fifo_head", r, {15'd0, 1'b1, refq.pop_front()});
      arm_wr(3'd4, 32'd0);
    end
    arm_wr(3'd4, 32'd0);
    arm_rd(3'd2, r);
    chk("fifo_empty_level", r, 32'd0);

    // DATI x3 at 001000
    dq = '{16'o111, 16'o222, 16'o333};
    run_xfer(2'd0, 18'o001000, 3, aend);
    wait_idle("dati_idle", 500);
    arm_rd(3'd2, r);
    chk("dati_level", r, 32'd3);
    arm_rd(3'd1, r);
    chk("dati_reg1", r, {14'd0, 18'o001006});
    pop_check("dati_pop", 3);
    chk("dati_expq", 32'(exp_q.size()), 32'd0);

    // DATO x2
    dq = '{16'o052525, 16'o125252};
    run_xfer(2'd2, 18'o002000, 2, aend);
    wait_idle("dato_idle", 500);
    arm_rd(3'd1, r);
    chk("dato_reg1", r, {5'd0, 2'd2, 7'd0, 18'o002004});
    chk("dato_expq", 32'(exp_q.size()), 32'd0);

    // DATOB wraps 777777 -> 0
    dq = '{16'h0011, 16'h0022, 16'h0033};
    run_xfer(2'd3, 18'o777776, 3, aend);
    wait_idle("datob_idle", 500);
    arm_rd(3'd1, r);
    chk("datob_reg1", r, {5'd0, 2'd3, 7'd0, 18'o000001});
    chk("datob_expq", 32'(exp_q.size()), 32'd0);

    // Start with count=0 does nothing
    arm_wr(3'd2, 32'd0);
    arm_wr(3'd1, {4'h8, 2'd2, 8'd0, 18'o000100});
    cycles(3);
    arm_rd(3'd1, r);
    chk("cnt0_busy_state", {27'd0, r[31:27]}, 32'd0);

    // KY fails the second word
    fail_at = int'(18'o002002);
    dq = '{16'o444};
    exp_q.push_back({3'd3, r3w(2'd0, 18'o002000)});
    exp_q.push_back({3'd3, r3w(2'd0, 18'o002002)});
    dati_q.push_back(16'o444);
    arm_wr(3'd2, 32'd3);
    arm_wr(3'd1, {4'h8, 2'd0, 8'd0, 18'o002000});
    wait_idle("fail_idle", 500);
    arm_rd(3'd1, r);
    chk("fail_reg1", r, {2'b01, 12'd0, 18'o002002});
    arm_rd(3'd2, r);
    chk("fail_reg2", r, {4'd0, 12'd2, 11'd0, 5'd1});
    pop_check("fail_pop", 1);
    chk("fail_expq", 32'(exp_q.size()), 32'd0);
    fail_at = -1;

    // ky_armbusy held 5 cycles in START
    force_busy = 1'b1;
    dq = '{16'o777};
    run_xfer(2'd0, 18'o001000, 1, aend);
    repeat (5) begin
      @(negedge clk);
      chk("busy_nowrite", {31'd0, ky_write}, 32'd0);
      @(posedge clk);
      #1;
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_write", {31'd0, ky_write}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle("busy_idle", 500);
    pop_check("busy_pop", 1);
    chk("busy_expq", 32'(exp_q.size()), 32'd0);

    // Abort during POLL with a slow KY
    lat = 20;
    dq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_q.push_back({3'd4, {16'd0, dq[0]}});
    exp_q.push_back({3'd3, r3w(2'd2, 18'o003000)});
    for (int i = 0; i < 4; i++) arm_wr(3'd3, {16'd0, dq[i]});
    arm_wr(3'd2, 32'd4);
    arm_wr(3'd1, {4'h8, 2'd2, 8'd0, 18'o003000});
    for (int k = 0; k < 50; k++) begin
      arm_rd(3'd1, r);
      if (r[29:27] == 3'd3) break;
      cycles(1);
    end
    chk("abort_in_poll", {29'd0, r[29:27]}, 32'd3);
    arm_wr(3'd1, 32'h4000_0000);
    wait_idle("abort_idle", 500);
    cycles(10);
    arm_rd(3'd1, r);
    chk("abort_flags", {27'd0, r[31:27]}, 32'b01000);
    arm_rd(3'd2, r);
    chk("abort_level", {27'd0, r[4:0]}, 32'd0);
    chk("abort_expq", 32'(exp_q.size()), 32'd0);

    // Random transfers with ARM noise on KY
    noise_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      logic [1:0] c;
      logic [17:0] a0;
      int n;
      int sel = $urandom_range(0, 2);
      c = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd2 : 2'd3;
      n = $urandom_range(1, 8);
      a0 = 18'($urandom);
      if (c != 2'd3) a0[0] = 1'b0;
      lat = $urandom_range(1, 6);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(16'($urandom));
      run_xfer(c, a0, n, aend);
      wait_idle("rnd_idle", 2000);
      arm_rd(3'd1, r);
      chk("rnd_reg1", r, {5'd0, c, 7'd0, aend});
      arm_rd(3'd2, r);
      chk("rnd_reg2", r, {27'd0, (c == 2'd0) ? 5'(n) : 5'd0});
      if (c == 2'd0) pop_check("rnd_pop", n);
      chk("rnd_expq", 32'(exp_q.size()), 32'd0);
    end
    noise_en = 1'b0;

    // RESET mid-DATI
    lat = 3;
    dq = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
    run_xfer(2'd0, 18'o004000, 6, aend);
    cycles(7);
    rst = 1'b1;
    #1;
    chk("mid_rst_kywrite", {31'd0, ky_write}, 32'd0);
    chk("mid_rst_kywaddr", {29'd0, ky_waddr}, 32'd0);
    chk("mid_rst_kywdata", ky_wdata, 32'd0);
    chk("mid_rst_kyraddr", {29'd0, ky_raddr}, 32'd3);
    arm_rd(3'd1, r);
    chk("mid_rst_reg1", r, 32'd0);
    arm_rd(3'd2, r);
    chk("mid_rst_reg2", r, 32'd0);
    exp_q.delete();
    dati_q.delete();
    cycles(2);
    rst = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
